// File: rtl/usr_seq_if.sv
// Command/handshake bundle between a host FSM and the usr sequencer,
// including the mode/data pins that go on to the usr instance.
interface usr_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             abort;
    logic [1:0]       usr_mode;
    logic [WIDTH-1:0] usr_data;
    logic             busy;
    logic             done;
    logic             aborted;

    // host side
    modport master (
        output cmd_valid, cmd_load, cmd_dir, cmd_count, cmd_data, abort,
        input  cmd_ready, usr_mode, usr_data, busy, done, aborted
    );

    // sequencer side
    modport slave (
        input  cmd_valid, cmd_load, cmd_dir, cmd_count, cmd_data, abort,
        output cmd_ready, usr_mode, usr_data, busy, done, aborted
    );
endinterface

// File: rtl/usr_seq.sv
// Sequencer for the 4-bit universal shift register: takes one command
// (optional parallel load followed by N shifts in one direction), drives
// usr mode/data cycle by cycle and pulses done (with aborted) at the end.
// All status/mode outputs decode from registered state only.
module usr_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic     clk,
    input  logic     rst,
    usr_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic [WIDTH-1:0] data_q;
    logic             abt_q;

    // Command FSM: accept in IDLE, one LOAD cycle, cnt SHIFT cycles, one DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dir_q  <= 1'b0;
            data_q <= '0;
            abt_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // abort is ignored here, even alongside a new command
                    if (bus.cmd_valid) begin
                        data_q <= bus.cmd_data;
                        dir_q  <= bus.cmd_dir;
                        cnt    <= bus.cmd_count;
                        abt_q  <= 1'b0;
                        if (bus.cmd_load)
                            state <= LOAD;
                        else if (bus.cmd_count != '0)
                            state <= SHIFT;
                        else
                            state <= DONE;
                    end
                end
                LOAD: begin
                    // the load itself still happens this cycle
                    if (bus.abort) begin
                        abt_q <= 1'b1;
                        cnt   <= '0;
                        state <= DONE;
                    end else if (cnt != '0) begin
                        state <= SHIFT;
                    end else begin
                        state <= DONE;
                    end
                end
                SHIFT: begin
                    // current shift is applied; abort only stops further ones
                    if (bus.abort) begin
                        abt_q <= 1'b1;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt <= CNT_W'(1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mode pins decoded from state and the latched direction.
    always_comb begin
        bus.usr_mode = 2'b00;
        case (state)
            LOAD:    bus.usr_mode = 2'b01;
            SHIFT:   bus.usr_mode = {1'b1, dir_q};
            default: bus.usr_mode = 2'b00;
        endcase
    end

    assign bus.usr_data  = data_q;
    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state == LOAD) || (state == SHIFT);
    assign bus.done      = (state == DONE);
    assign bus.aborted   = (state == DONE) && abt_q;
endmodule

// File: tb/tb_usr_seq.sv
// Directed bench for usr_seq: table of commands with hand-computed results,
// plus hand sequences for held cmd_valid, abort and mid-command reset.
// A small usr model follows the mode/data pins to check the register value.
module tb_usr_seq;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] y;

    usr_seq_if #(.WIDTH(4), .CNT_W(3)) bus ();

    usr_seq #(.WIDTH(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // usr model: serial-in bits are 0
    always @(posedge clk or negedge rst) begin
        if (!rst) y <= 4'b0000;
        else begin
            case (bus.usr_mode)
                2'b01:   y <= bus.usr_data;
                2'b10:   y <= {1'b0, y[3:1]};
                2'b11:   y <= {y[2:0], 1'b0};
                default: y <= y;
            endcase
        end
    end

    typedef struct {
        logic       ld;
        logic       dr;
        logic [2:0] cn;
        logic [3:0] dt;
        logic [3:0] exp_y;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command in IDLE, check every cycle up to done, end back in IDLE.
    task automatic run_cmd(input logic ld, input logic dr, input logic [2:0] cn,
                           input logic [3:0] dt, input logic ab);
        int lat;
        logic [1:0] em;
        lat = int'(ld) + int'(cn) + 1;
        check("ready_before", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = ld;
        bus.cmd_dir   = dr;
        bus.cmd_count = cn;
        bus.cmd_data  = dt;
        bus.abort     = ab;
        step();
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
        bus.cmd_data  = ~dt;
        for (int c = 1; c <= lat; c++) begin
            if (c <= int'(ld))  em = 2'b01;
            else if (c < lat)   em = {1'b1, dr};
            else                em = 2'b00;
            check("mode", bus.usr_mode, em);
            check("done", bus.done, c == lat);
            check("busy", bus.busy, c < lat);
            check("ready_busy", bus.cmd_ready, 0);
            check("data_held", bus.usr_data, dt);
            if (c == lat) check("aborted_norm", bus.aborted, 0);
            else step();
        end
        step();
        check("ready_after", bus.cmd_ready, 1);
        check("done_after", bus.done, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 3'd0, 4'b1011, 4'b1011};
        vecs[1] = '{1'b1, 1'b1, 3'd4, 4'b1101, 4'b0000};
        vecs[2] = '{1'b1, 1'b0, 3'd2, 4'b1001, 4'b0010};
        vecs[3] = '{1'b0, 1'b0, 3'd0, 4'b1111, 4'b0010};
        vecs[4] = '{1'b1, 1'b1, 3'd1, 4'b0110, 4'b1100};
        vecs[5] = '{1'b0, 1'b0, 3'd3, 4'b0000, 4'b0001};
        vecs[6] = '{1'b0, 1'b1, 3'd2, 4'b0000, 4'b0100};
        vecs[7] = '{1'b0, 1'b0, 3'd7, 4'b0000, 4'b0000};

        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_count = 3'd0;
        bus.cmd_data  = 4'b0000;
        bus.abort     = 1'b0;
        #12 rst = 1'b1;
        #1;
        check("rst_mode", bus.usr_mode, 0);
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_aborted", bus.aborted, 0);
        check("rst_data", bus.usr_data, 0);
        step();

        // table of commands
        foreach (vecs[i]) begin
            run_cmd(vecs[i].ld, vecs[i].dr, vecs[i].cn, vecs[i].dt, 1'b0);
            check("vec_y", y, vecs[i].exp_y);
        end

        // cmd_valid held high across a 7-shift command with new data waiting
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_count = 3'd7;
        bus.cmd_data  = 4'b1010;
        step();
        bus.cmd_load  = 1'b1;
        bus.cmd_count = 3'd0;
        bus.cmd_data  = 4'b0101;
        for (int c = 1; c <= 8; c++) begin
            check("held_mode", bus.usr_mode, (c < 8) ? 2'b10 : 2'b00);
            check("held_done", bus.done, c == 8);
            check("held_data", bus.usr_data, 4'b1010);
            step();
        end
        check("held_idle_ready", bus.cmd_ready, 1);
        check("held_idle_data", bus.usr_data, 4'b1010);
        check("held_idle_mode", bus.usr_mode, 0);
        step();
        bus.cmd_valid = 1'b0;
        check("held2_mode", bus.usr_mode, 2'b01);
        check("held2_data", bus.usr_data, 4'b0101);
        step();
        check("held2_done", bus.done, 1);
        step();
        check("held2_y", y, 4'b0101);

        // abort during the 2nd shift of a 5-shift left command
        run_cmd(1'b1, 1'b0, 3'd0, 4'b0011, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b0;
        bus.cmd_dir   = 1'b1;
        bus.cmd_count = 3'd5;
        step();
        bus.cmd_valid = 1'b0;
        check("abt_mode1", bus.usr_mode, 2'b11);
        step();
        check("abt_mode2", bus.usr_mode, 2'b11);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abt_mode3", bus.usr_mode, 0);
        check("abt_done", bus.done, 1);
        check("abt_flag", bus.aborted, 1);
        check("abt_busy", bus.busy, 0);
        step();
        check("abt_y", y, 4'b1100);
        check("abt_done_gone", bus.done, 0);
        run_cmd(1'b1, 1'b0, 3'd1, 4'b0101, 1'b0);
        check("abt_next_y", y, 4'b0010);

        // reset pulled mid-shift, then a load with a same-cycle abort (ignored)
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b0;
        bus.cmd_dir   = 1'b1;
        bus.cmd_count = 3'd6;
        step();
        bus.cmd_valid = 1'b0;
        step();
        check("mid_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        check("mrst_mode", bus.usr_mode, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_done", bus.done, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("mrst_hold_done", bus.done, 0);
            check("mrst_hold_mode", bus.usr_mode, 0);
        end
        rst = 1'b1;
        step();
        run_cmd(1'b1, 1'b0, 3'd0, 4'b0110, 1'b1);
        check("mrst_y", y, 4'b0110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
